// File: rtl/ptw_arb.sv
// Page-table-walk arbiter: round-robin grants one TLB channel at a time, runs a fixed-latency
// walk and returns a translated PPN (or a fault) to the served channel.
module ptw_arb #(
  parameter int          NUM_CH      = 2,
  parameter int          VA_WIDTH    = 20,
  parameter int          PPN_WIDTH   = 8,
  parameter int          PTW_LATENCY = 3,
  parameter logic [31:0] PPN_OFFSET  = 32'd0,
  parameter logic [63:0] VA_LIMIT    = (64'd1 << VA_WIDTH) - 64'd1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*VA_WIDTH-1:0]   req_va,
  input  logic                         flush,
  output logic [NUM_CH-1:0]            req_grant,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic [PPN_WIDTH-1:0]         resp_ppn,
  output logic                         resp_fault,
  output logic                         busy,
  output logic [15:0]                  walk_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (PTW_LATENCY > 1) ? $clog2(PTW_LATENCY) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(PTW_LATENCY - 1);
  localparam logic [PPN_WIDTH-1:0] C_OFFSET = PPN_OFFSET[PPN_WIDTH-1:0];
  // A limit beyond the VA space means no address can fault; saturate it to 2**VA_WIDTH.
  localparam logic [63:0] C_LIMIT_SAT = (VA_LIMIT > (64'd1 << VA_WIDTH)) ? (64'd1 << VA_WIDTH) : VA_LIMIT;
  localparam logic [VA_WIDTH:0] C_LIMIT = C_LIMIT_SAT[VA_WIDTH:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [NUM_CH-1:0]       r_served;
  logic [VA_WIDTH-1:0]     r_va;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_CH-1:0]       r_req_grant;
  logic [NUM_CH-1:0]       r_resp_valid;
  logic [PPN_WIDTH-1:0]    r_resp_ppn;
  logic                    r_resp_fault;
  logic                    r_busy;
  logic [15:0]             r_walk_count;

  logic [VA_WIDTH-1:0]     w_va_arr [NUM_CH];
  logic [NUM_CH-1:0]       w_elig;
  logic                    w_found;
  logic [IDX_W-1:0]        w_sel;
  logic [NUM_CH-1:0]       w_sel_oh;
  logic [NUM_CH-1:0]       w_idx_oh;
  logic [IDX_W-1:0]        w_rr_next;
  logic [PPN_WIDTH-1:0]    w_ppn_sum;
  logic                    w_fault;
  logic [PPN_WIDTH-1:0]    w_ppn;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_CH);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_va_arr[gi] = req_va[gi*VA_WIDTH +: VA_WIDTH];
      assign w_sel_oh[gi] = (w_sel == IDX_W'(gi));
      assign w_idx_oh[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // The channel just served is masked for one IDLE cycle so its still-held level is not re-taken.
  assign w_elig = req & ~r_served;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_elig[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_rr_next = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + IDX_W'(1);
  assign w_ppn_sum = r_va[PPN_WIDTH-1:0] + C_OFFSET;
  assign w_fault   = ({1'b0, r_va} >= C_LIMIT);
  assign w_ppn     = w_fault ? '0 : w_ppn_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_served     <= '0;
      r_va         <= '0;
      r_idx        <= '0;
      r_req_grant  <= '0;
      r_resp_valid <= '0;
      r_resp_ppn   <= '0;
      r_resp_fault <= 1'b0;
      r_busy       <= 1'b0;
      r_walk_count <= '0;
    end else begin
      r_req_grant  <= '0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          r_served <= '0;
          if (!flush && w_found) begin
            r_state     <= S_WALK;
            r_busy      <= 1'b1;
            r_va        <= w_va_arr[w_sel];
            r_idx       <= w_sel;
            r_cnt       <= C_CNT_INIT;
            r_req_grant <= w_sel_oh;
            r_rr_ptr    <= w_rr_next;
          end
        end
        S_WALK: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= w_idx_oh;
            r_resp_ppn   <= w_ppn;
            r_resp_fault <= w_fault;
            if (r_walk_count != 16'hFFFF) begin
              r_walk_count <= r_walk_count + 16'd1;
            end
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_served <= w_idx_oh;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_grant  = r_req_grant;
  assign resp_valid = r_resp_valid;
  assign resp_ppn   = r_resp_ppn;
  assign resp_fault = r_resp_fault;
  assign busy       = r_busy;
  assign walk_count = r_walk_count;

endmodule

// File: tb/tb_ptw_arb.sv
// Bench for ptw_arb: two instances (2-ch latency 3 with VA limit 0x80000, 3-ch latency 1 with
// PPN offset 4); expected responses are queued when requests are raised and popped on resp_valid.
module tb_ptw_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req0;
  logic [39:0] req_va0;
  logic        flush0;
  logic [1:0]  grant0, rv0;
  logic [7:0]  ppn0;
  logic        fault0, busy0;
  logic [15:0] wc0;

  logic [2:0]  req1;
  logic [59:0] req_va1;
  logic        flush1;
  logic [2:0]  grant1, rv1;
  logic [7:0]  ppn1;
  logic        fault1, busy1;
  logic [15:0] wc1;

  ptw_arb #(
    .NUM_CH(2), .VA_WIDTH(20), .PPN_WIDTH(8), .PTW_LATENCY(3),
    .PPN_OFFSET(32'd0), .VA_LIMIT(64'h80000)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_va(req_va0), .flush(flush0),
    .req_grant(grant0), .resp_valid(rv0), .resp_ppn(ppn0), .resp_fault(fault0),
    .busy(busy0), .walk_count(wc0)
  );

  ptw_arb #(
    .NUM_CH(3), .VA_WIDTH(20), .PPN_WIDTH(8), .PTW_LATENCY(1), .PPN_OFFSET(32'd4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_va(req_va1), .flush(flush1),
    .req_grant(grant1), .resp_valid(rv1), .resp_ppn(ppn1), .resp_fault(fault1),
    .busy(busy1), .walk_count(wc1)
  );

  typedef struct {
    int         ch;
    logic [7:0] ppn;
    logic       fault;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic set_va0(input int ch, input logic [19:0] va);
    req_va0[ch*20 +: 20] = va;
  endtask

  task automatic set_va1(input int ch, input logic [19:0] va);
    req_va1[ch*20 +: 20] = va;
  endtask

  task automatic wait_grant0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (grant0 != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_resp0(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (rv0 != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_grant1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (grant1 != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_resp1(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (rv1 != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({grant0, rv0, ppn0, fault0, busy0, wc0} !== 30'd0) begin
      n_errors++;
      $display("FAIL reset_dut0: got %h want 0", {grant0, rv0, ppn0, fault0, busy0, wc0});
    end
    n_checks++;
    if ({grant1, rv1, ppn1, fault1, busy1, wc1} !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_dut1: got %h want 0", {grant1, rv1, ppn1, fault1, busy1, wc1});
    end
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    exp_t e;
    set_va0(0, 20'h00123);
    req0 = 2'b01;
    q0.push_back('{0, 8'h23, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant0 !== 2'b01 || busy0 !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_first_grant: got grant=%b busy=%b want grant=01 busy=1", grant0, busy0);
    end
    wait_resp0(ok, cyc);
    n_checks++;
    if (!ok || cyc != 3) begin
      n_errors++;
      $display("FAIL basic_latency: got ok=%0d cycles=%0d want 3", ok, cyc);
    end
    if (ok) begin
      e = q0.pop_front();
      n_checks++;
      if (rv0 !== 2'b01 || ppn0 !== e.ppn || fault0 !== e.fault) begin
        n_errors++;
        $display("FAIL basic_resp: got rv=%b ppn=%h fault=%b want rv=01 ppn=%h fault=%b",
                 rv0, ppn0, fault0, e.ppn, e.fault);
      end
    end
    req0 = 2'b00;
    @(negedge clk);
    n_checks++;
    if (wc0 !== 16'd1 || rv0 !== 2'b00 || ppn0 !== 8'h23 || busy0 !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_after: got wc=%0d rv=%b ppn=%h busy=%b want wc=1 rv=00 ppn=23 busy=0",
               wc0, rv0, ppn0, busy0);
    end
  endtask

  task automatic test_fault();
    bit ok;
    int cyc;
    exp_t e;
    int ch_tab[3];
    logic [19:0] va_tab[3];
    logic [7:0] ppn_tab[3];
    logic f_tab[3];
    logic [1:0] oh;
    ch_tab = '{1, 0, 1};
    va_tab = '{20'h80000, 20'h7FFFF, 20'hFFFFF};
    ppn_tab = '{8'h00, 8'hFF, 8'h00};
    f_tab = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      set_va0(ch_tab[t], va_tab[t]);
      oh = 2'b01 << ch_tab[t];
      req0 = oh;
      q0.push_back('{ch_tab[t], ppn_tab[t], f_tab[t]});
      wait_grant0(ok);
      n_checks++;
      if (!ok || grant0 !== oh) begin
        n_errors++;
        $display("FAIL fault_grant[%0d]: got ok=%0d grant=%b want %b", t, ok, grant0, oh);
      end
      wait_resp0(ok, cyc);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL fault_resp_timeout[%0d]: got no resp_valid want one", t);
      end else begin
        e = q0.pop_front();
        oh = 2'b01 << e.ch;
        if (rv0 !== oh || ppn0 !== e.ppn || fault0 !== e.fault) begin
          n_errors++;
          $display("FAIL fault_resp[%0d]: got rv=%b ppn=%h fault=%b want rv=%b ppn=%h fault=%b",
                   t, rv0, ppn0, fault0, oh, e.ppn, e.fault);
        end
      end
      req0 = 2'b00;
    end
    @(negedge clk);
    n_checks++;
    if (wc0 !== 16'd4) begin
      n_errors++;
      $display("FAIL fault_count: got %0d want 4", wc0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    exp_t e;
    logic [1:0] oh;
    set_va0(0, 20'h00011);
    set_va0(1, 20'h00A22);
    req0 = 2'b11;
    for (int w = 0; w < 4; w++) begin
      if (w % 2 == 0) q0.push_back('{0, 8'h11, 1'b0});
      else            q0.push_back('{1, 8'h22, 1'b0});
      oh = 2'b01 << (w % 2);
      wait_grant0(ok);
      n_checks++;
      if (!ok || grant0 !== oh) begin
        n_errors++;
        $display("FAIL b2b_grant[%0d]: got ok=%0d grant=%b want %b", w, ok, grant0, oh);
      end
      wait_resp0(ok, cyc);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL b2b_resp_timeout[%0d]: got no resp_valid want one", w);
      end else begin
        e = q0.pop_front();
        oh = 2'b01 << e.ch;
        if (rv0 !== oh || ppn0 !== e.ppn || fault0 !== e.fault) begin
          n_errors++;
          $display("FAIL b2b_resp[%0d]: got rv=%b ppn=%h fault=%b want rv=%b ppn=%h fault=%b",
                   w, rv0, ppn0, fault0, oh, e.ppn, e.fault);
        end
      end
    end
    req0 = 2'b00;
    @(negedge clk);
    n_checks++;
    if (wc0 !== 16'd8 || busy0 !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_count: got wc=%0d busy=%b want wc=8 busy=0", wc0, busy0);
    end
  endtask

  task automatic test_flush();
    bit ok;
    bit saw;
    int cyc;
    exp_t e;
    set_va0(0, 20'h00055);
    req0 = 2'b01;
    wait_grant0(ok);
    n_checks++;
    if (!ok || grant0 !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_grant: got ok=%0d grant=%b want 01", ok, grant0);
    end
    flush0 = 1'b1;
    saw = 1'b0;
    @(negedge clk);
    if (rv0 != '0) saw = 1'b1;
    n_checks++;
    if (busy0 !== 1'b0 || wc0 !== 16'd8) begin
      n_errors++;
      $display("FAIL flush_abort: got busy=%b wc=%0d want busy=0 wc=8", busy0, wc0);
    end
    @(negedge clk);
    if (rv0 != '0) saw = 1'b1;
    n_checks++;
    if (grant0 !== 2'b00 || busy0 !== 1'b0 || saw) begin
      n_errors++;
      $display("FAIL flush_priority: got grant=%b busy=%b resp_seen=%0d want 00 0 0", grant0, busy0, saw);
    end
    flush0 = 1'b0;
    q0.push_back('{0, 8'h55, 1'b0});
    wait_grant0(ok);
    n_checks++;
    if (!ok || grant0 !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_regrant: got ok=%0d grant=%b want 01", ok, grant0);
    end
    wait_resp0(ok, cyc);
    n_checks++;
    if (!ok || cyc != 3) begin
      n_errors++;
      $display("FAIL flush_resp_latency: got ok=%0d cycles=%0d want 3", ok, cyc);
    end
    if (ok) begin
      e = q0.pop_front();
      n_checks++;
      if (rv0 !== 2'b01 || ppn0 !== e.ppn || fault0 !== e.fault) begin
        n_errors++;
        $display("FAIL flush_resp: got rv=%b ppn=%h fault=%b want rv=01 ppn=%h fault=%b",
                 rv0, ppn0, fault0, e.ppn, e.fault);
      end
    end
    req0 = 2'b00;
    @(negedge clk);
    n_checks++;
    if (wc0 !== 16'd9) begin
      n_errors++;
      $display("FAIL flush_count: got %0d want 9", wc0);
    end
  endtask

  task automatic test_reset_mid_walk();
    bit ok;
    bit saw;
    set_va0(1, 20'h00077);
    req0 = 2'b10;
    wait_grant0(ok);
    n_checks++;
    if (!ok || grant0 !== 2'b10) begin
      n_errors++;
      $display("FAIL rstwalk_grant: got ok=%0d grant=%b want 10", ok, grant0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant0, rv0, ppn0, fault0, busy0, wc0} !== 30'd0) begin
      n_errors++;
      $display("FAIL rstwalk_async: got %h want 0", {grant0, rv0, ppn0, fault0, busy0, wc0});
    end
    req0 = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rv0 != '0) saw = 1'b1;
    end
    n_checks++;
    if (saw || wc0 !== 16'd0) begin
      n_errors++;
      $display("FAIL rstwalk_no_resp: got resp_seen=%0d wc=%0d want 0 0", saw, wc0);
    end
  endtask

  task automatic test_rr_three();
    bit ok;
    int cyc;
    exp_t e;
    logic [2:0] oh;
    logic [7:0] ppn_tab[3];
    logic f_tab[3];
    ppn_tab = '{8'h14, 8'h02, 8'h00};
    f_tab = '{1'b0, 1'b0, 1'b1};
    set_va1(0, 20'h00010);
    set_va1(1, 20'h000FE);
    set_va1(2, 20'hFFFFF);
    req1 = 3'b111;
    for (int w = 0; w < 6; w++) begin
      q1.push_back('{w % 3, ppn_tab[w % 3], f_tab[w % 3]});
      oh = 3'b001 << (w % 3);
      wait_grant1(ok);
      n_checks++;
      if (!ok || grant1 !== oh) begin
        n_errors++;
        $display("FAIL rr3_grant[%0d]: got ok=%0d grant=%b want %b", w, ok, grant1, oh);
      end
      wait_resp1(ok, cyc);
      n_checks++;
      if (!ok || cyc != 1) begin
        n_errors++;
        $display("FAIL rr3_latency[%0d]: got ok=%0d cycles=%0d want 1", w, ok, cyc);
      end
      if (ok) begin
        e = q1.pop_front();
        oh = 3'b001 << e.ch;
        n_checks++;
        if (rv1 !== oh || ppn1 !== e.ppn || fault1 !== e.fault) begin
          n_errors++;
          $display("FAIL rr3_resp[%0d]: got rv=%b ppn=%h fault=%b want rv=%b ppn=%h fault=%b",
                   w, rv1, ppn1, fault1, oh, e.ppn, e.fault);
        end
      end
    end
    req1 = 3'b000;
    @(negedge clk);
    n_checks++;
    if (wc1 !== 16'd6 || busy1 !== 1'b0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL rr3_count: got wc=%0d busy=%b pending=%0d want 6 0 0", wc1, busy1, q1.size());
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req0    = '0;
    req_va0 = '0;
    flush0  = 1'b0;
    req1    = '0;
    req_va1 = '0;
    flush1  = 1'b0;
    test_reset();
    test_basic();
    test_fault();
    test_back_to_back();
    test_flush();
    test_reset_mid_walk();
    test_rr_three();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ptw_arb.md
PTW_ARB -- requirements
Module: ptw_arb

Interface
REQ-001 Parameter NUM_CH, default 2: number of requesting TLB channels; legal range 1..8.
REQ-002 Parameter VA_WIDTH, default 20: virtual address width.
REQ-003 Parameter PPN_WIDTH, default 8: returned PPN width; must be <= VA_WIDTH.
REQ-004 Parameter PTW_LATENCY, default 3: cycles from accept to response; legal range >= 1.
REQ-005 Parameter PPN_OFFSET, default 0: constant added to the VA low bits to form the PPN.
REQ-006 Parameter VA_LIMIT, default 2**VA_WIDTH-1: VAs >= VA_LIMIT produce a fault.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 req  input  NUM_CH  per-channel level translation request; held until that channel's resp_valid.
REQ-010 req_va  input  NUM_CH*VA_WIDTH  per-channel VA; channel i occupies bits [i*VA_WIDTH +: VA_WIDTH].
REQ-011 flush  input  1  abort any walk in progress; no response is issued for it.
REQ-012 req_grant  output  NUM_CH  one-hot, registered, 1-cycle pulse when a channel's request is accepted.
REQ-013 resp_valid  output  NUM_CH  one-hot, registered, 1-cycle pulse to the served channel.
REQ-014 resp_ppn  output  PPN_WIDTH  shared result bus; valid only while any resp_valid bit is high.
REQ-015 resp_fault  output  1  shared fault flag; qualified by resp_valid.
REQ-016 busy  output  1  high in WALK and RESP.
REQ-017 walk_count  output  16  saturating count of completed (non-flushed) walks.

Function
REQ-018 FSM states: IDLE, WALK, RESP; encoding is free.
REQ-019 IDLE: if any eligible req bit is high, select one channel round-robin, latch its VA and channel index, load cnt = PTW_LATENCY-1, pulse req_grant for that channel, and go to WALK.
REQ-020 Round-robin: search starts at the channel after the last granted channel, wrapping NUM_CH-1 -> 0; after reset the search starts at channel 0.
REQ-021 Eligible means req high and not the channel that was served in the immediately preceding RESP cycle; this mask applies for the single IDLE cycle following RESP only.
REQ-022 WALK: if cnt != 0, decrement cnt; if cnt == 0, go to RESP and register the response outputs.
REQ-023 Latency: with accept at edge k, resp_valid is high in the cycle after edge k+PTW_LATENCY; with PTW_LATENCY=1 the response occurs one cycle after accept.
REQ-024 Translation: resp_ppn = (latched_va[PPN_WIDTH-1:0] + PPN_OFFSET) mod 2**PPN_WIDTH; the carry is discarded.
REQ-025 Fault: resp_fault = 1 and resp_ppn = 0 when latched_va >= VA_LIMIT; otherwise resp_fault = 0.
REQ-026 RESP: resp_valid is high for exactly this one cycle; walk_count increments (saturating at 16'hFFFF); the FSM returns to IDLE.
REQ-027 Outside RESP: resp_valid = 0; resp_ppn and resp_fault hold their last values.
REQ-028 flush in IDLE or WALK forces IDLE on the next edge with no req_grant, no resp_valid, and no walk_count change.
REQ-029 flush takes priority over a new accept in the same cycle.
REQ-030 flush in RESP has no effect: the response completes normally.
REQ-031 Request inputs are ignored in WALK and RESP; exactly one walk is outstanding at any time.
REQ-032 Simultaneous requests on all channels are served one per walk, in round-robin order, with no starvation.

Reset
REQ-033 While rst_n = 0: state = IDLE, cnt = 0, rr pointer = channel 0, served-mask cleared, latched VA/index = 0.
REQ-034 While rst_n = 0: req_grant = 0, resp_valid = 0, resp_ppn = 0, resp_fault = 0, busy = 0, walk_count = 0.
REQ-035 Reset asserted mid-walk discards the walk immediately with no response issued.
REQ-036 The first accept can occur on the first rising edge after rst_n deasserts.

Verification
REQ-037 NUM_CH=2, PTW_LATENCY=3: ch0 req with VA 0x00123, accepted at edge k -> req_grant=01 at k; resp_valid=01, resp_ppn=0x23, fault=0 after edge k+3; walk_count=1.
REQ-038 PPN_OFFSET=4: VA 0x000FE -> resp_ppn=0x02 (carry wraps).
REQ-039 VA_LIMIT=0x80000: VA 0x80000 -> resp_fault=1, resp_ppn=0x00; VA 0x7FFFF -> resp_fault=0, resp_ppn=0xFF.
REQ-040 ch0 and ch1 held high continuously -> grants alternate ch0, ch1, ch0, ...; each channel receives resp_valid exactly once per walk.
REQ-041 flush asserted the cycle after accept -> FSM returns to IDLE; no resp_valid; walk_count unchanged; a request still held is re-accepted afterwards.
REQ-042 rst_n pulled low during WALK -> all outputs 0 asynchronously; no resp_valid after release.
